// File: rtl/mem_access_stage.sv
// MEM stage of the in-order pipeline: data-memory request/grant/rvalid handshake,
// store byte-lane steering, load extraction, and the MEM/WB pipeline register.

module mem_store_lane #(
  parameter int LANE = 0
) (
  input  logic       isStore,
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] ownByte,
  input  logic [7:0] lowByte,
  input  logic [7:0] halfByte,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wbyte = ownByte;
    if (isStore) begin
      case (size)
        2'b00: begin be = (off == L);       wbyte = lowByte;  end
        2'b01: begin be = (off[1] == L[1]); wbyte = halfByte; end
        default: ;
      endcase
    end
  end
endmodule

module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_m,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic [4:0]      RdM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            misalign_m,
  output logic            valid_w,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] LoadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ImmExtW
);
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RD} state_t;
  state_t state, stateNxt;

  logic       isLoad, access, misaligned, issue, reqC, stallC, loadDone;
  logic [1:0] off;
  logic [XLEN-1:0] shifted, loadExt;
  logic [NUM_LANES-1:0][7:0] wdataLanes;

  assign off    = ALUResultM[1:0];
  assign isLoad = (ResultSrcM == 2'b01);
  assign access = valid_m & (MemWriteM | isLoad);

  // funct3[1:0]: 00 byte, 01 half, anything else is a word access
  always_comb begin
    case (funct3M[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = |off;
    endcase
  end

  assign issue      = access & ~misaligned;
  assign misalign_m = rst_n & access & misaligned;

  always_comb begin
    stateNxt = state;
    reqC     = 1'b0;
    stallC   = 1'b0;
    case (state)
      IDLE: if (issue) begin
        reqC = 1'b1;
        if (!dmem_gnt) begin
          stateNxt = WAIT_GNT;
          stallC   = 1'b1;
        end else if (isLoad) begin
          stateNxt = WAIT_RD;
          stallC   = 1'b1;
        end
      end
      WAIT_GNT: begin
        reqC = 1'b1;
        if (!dmem_gnt) stallC = 1'b1;
        else if (isLoad) begin
          stateNxt = WAIT_RD;
          stallC   = 1'b1;
        end else stateNxt = IDLE;
      end
      WAIT_RD: begin
        if (dmem_rvalid) stateNxt = IDLE;
        else stallC = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  assign dmem_req  = rst_n & reqC;
  assign mem_stall = rst_n & stallC;
  assign dmem_we   = issue & ~isLoad;
  assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_store_lane #(.LANE(i)) u_lane (
      .isStore (~isLoad),
      .size    (funct3M[1:0]),
      .off     (off),
      .ownByte (WriteDataM[8*i +: 8]),
      .lowByte (WriteDataM[7:0]),
      .halfByte(WriteDataM[8*(i%2) +: 8]),
      .be      (dmem_be[i]),
      .wbyte   (wdataLanes[i])
    );
  end
  assign dmem_wdata = wdataLanes;

  assign shifted  = dmem_rdata >> {off, 3'b000};
  assign loadDone = (state == WAIT_RD) & dmem_rvalid;

  always_comb begin
    case (funct3M)
      3'b000:  loadExt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  loadExt = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  loadExt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  loadExt = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: loadExt = dmem_rdata;
    endcase
  end

  // A stalled cycle pushes a bubble; payload fields hold their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w    <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= '0;
      ALUResultW <= '0;
      LoadDataW  <= '0;
      PCPlus4W   <= '0;
      ImmExtW    <= '0;
    end else if (mem_stall) begin
      valid_w   <= 1'b0;
      RegWriteW <= 1'b0;
    end else begin
      valid_w    <= valid_m;
      RegWriteW  <= valid_m & RegWriteM & ~(access & misaligned);
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      LoadDataW  <= loadDone ? loadExt : '0;
      PCPlus4W   <= PCPlus4M;
      ImmExtW    <= ImmExtM;
    end
  end
endmodule
